hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised forwarding and hazard unit for the pipelined core; successor to the fixed two-source forwarder.
//  Tracks STAGES in-flight register writes in an internal tag/data pipeline.
//  Forwards the youngest matching result to NUM_RS decode source ports and raises load-use stalls.
//  Counts stall cycles for performance monitoring. Sits between decoder_stage and execute_stage.
// PARAMETERS
//  DWIDTH      32  data width
//  AWIDTH      5   register address width
//  NUM_RS      2   number of source read ports forwarded (1..4)
//  STAGES      3   tracked in-flight entries; entry 0 = EX, 1 = MEM, 2 = WB (2..8)
//  LOAD_STAGE  1   entry index at which load data becomes available (1..STAGES-1)
//  CNT_WIDTH   16  width of the stall-cycle counter
// PORTS
//  hz_clk          in   1               clock
//  hz_rst          in   1               synchronous active-high reset
//  hz_i_issue_valid in  1               decode instruction enters EX this cycle
//  hz_i_issue_we   in   1               issuing instruction writes rd
//  hz_i_issue_rd   in   AWIDTH          issuing destination register
//  hz_i_issue_load in   1               issuing instruction is a load
//  hz_i_addr_rs    in   NUM_RS*AWIDTH   decode source addresses; port n = bits [n*AWIDTH +: AWIDTH]
//  hz_i_data_rs    in   NUM_RS*DWIDTH   register-file read data per port
//  hz_i_alu_data   in   DWIDTH          ALU result of the entry at index 0
//  hz_i_load_data  in   DWIDTH          load data of the entry at LOAD_STAGE
//  hz_i_flush      in   1               kill the issuing instruction and the entry at index 0
//  hz_o_data_rs    out  NUM_RS*DWIDTH   resolved source operands
//  hz_o_fwd_hit    out  NUM_RS          per-port flag: operand taken from the pipeline
//  hz_o_stall      out  1               hold decode/fetch; a bubble is inserted into EX
//  hz_o_stall_cnt  out  CNT_WIDTH       saturating count of stall cycles
// BEHAVIOUR
//  - Entry k fields: valid, we, rd, is_load, data. An entry matches port n when it is valid and we=1,
//    rd == addr_rs[n], and rd != 0.
//  - Operand source per entry: k=0 uses hz_i_alu_data. k=LOAD_STAGE with is_load=1 uses hz_i_load_data.
//    All other entries use the stored data.
//  - Ready: a non-load entry is always ready. A load entry is ready when k >= LOAD_STAGE.
//  - Per port, the lowest-k matching entry wins. If none matches: data = hz_i_data_rs, hit = 0.
//  - Address 0 always yields data 0 with hit = 0, regardless of in-flight writes to x0.
//  - Forwarding and stall are combinational (0-cycle). Issuing instruction never matches itself.
//  - hz_o_stall = issue_valid & ~flush & (any port wins on a not-ready entry).
//  - Posedge, normal issue: entry[0] <= {issue_valid, we, rd, load}, entry[k] <= entry[k-1].
//  - On entry 0 -> 1: data <= hz_i_alu_data.
//  - On entry LOAD_STAGE -> LOAD_STAGE+1 with is_load=1: data <= hz_i_load_data.
//    Any other move copies data unchanged.
//  - Posedge, stall: entry[0] <= bubble (valid=0); entries 1..STAGES-1 still shift.
//  - Posedge, flush: entry[0] <= bubble and entry[1] <= invalid; deeper entries shift. Flush wins over stall.
//  - The oldest entry (STAGES-1) retires and is dropped every cycle.
//  - hz_o_stall_cnt increments on each cycle with hz_o_stall=1 and holds at 2^CNT_WIDTH-1.
//  - Reset: all entries valid=0, data=0; hz_o_stall_cnt=0. hz_o_stall=0, hz_o_fwd_hit=0 and
//    hz_o_data_rs = hz_i_data_rs (x0 forced 0). Reset mid-stall drops pending loads; no stall next cycle.
// TESTING
//  - ALU RAW: issue x5 we=1, alu_data=0x11; next cycle rs0=x5, rf=0 -> data_rs0=0x11, hit0=1, stall=0.
//  - Load-use (LOAD_STAGE=1): issue lw x6, next cycle rs1=x6 -> stall=1 for 1 cycle, cnt=1;
//    then load_data=0xDEADBEEF -> data_rs1=0xDEADBEEF, stall=0.
//  - Priority: x7=0xA in entry 1 and x7=0xB in entry 0; both ports read x7 -> both output 0xB, hits=2'b11.
//  - x0: in-flight write x0 with alu_data=0x5; rs0=x0, rf=0x3 -> data_rs0=0, hit0=0.
//  - Flush: issue x8 (alu 0x22), assert flush next cycle; later rs0=x8, rf=0x99 -> 0x99, hit0=0.
//  - Reset mid-op: pending lw x9 with stall=1, then hz_rst=1 -> next cycle stall=0, cnt=0, hit=0;
//    CNT_WIDTH=2 with 5 stall cycles -> cnt=3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding and load-use hazard unit for the pipelined core.
// Keeps a shift pipeline of in-flight register writes (entry 0 = EX, then MEM,
// WB, ...), resolves each decode source operand to the youngest matching
// in-flight result, and stalls decode when that result is a load that has not
// yet produced its data. Stall cycles are counted in a saturating counter.
module hazard_scoreboard #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 5,
    parameter int NUM_RS     = 2,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     hz_clk,
    input  logic                     hz_rst,
    input  logic                     hz_i_issue_valid,
    input  logic                     hz_i_issue_we,
    input  logic [AWIDTH-1:0]        hz_i_issue_rd,
    input  logic                     hz_i_issue_load,
    input  logic [NUM_RS*AWIDTH-1:0] hz_i_addr_rs,
    input  logic [NUM_RS*DWIDTH-1:0] hz_i_data_rs,
    input  logic [DWIDTH-1:0]        hz_i_alu_data,
    input  logic [DWIDTH-1:0]        hz_i_load_data,
    input  logic                     hz_i_flush,
    output logic [NUM_RS*DWIDTH-1:0] hz_o_data_rs,
    output logic [NUM_RS-1:0]        hz_o_fwd_hit,
    output logic                     hz_o_stall,
    output logic [CNT_WIDTH-1:0]     hz_o_stall_cnt
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // In-flight entry fields; entry 0 never stores data because its result
    // is still on the ALU output.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] we_q;
    logic [STAGES-1:0] ld_q;
    logic [AWIDTH-1:0] rd_q   [STAGES];
    logic [DWIDTH-1:0] data_q [1:STAGES-1];
    logic [CNT_WIDTH-1:0] cnt_q;

    // Per-entry operand value and readiness as seen by decode this cycle.
    logic [STAGES-1:0] rdy_w;
    logic [DWIDTH-1:0] op_data [STAGES];
    logic [NUM_RS-1:0] wait_w;
    logic              stall_w;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign rdy_w[k] = ~ld_q[k] | (k >= LOAD_STAGE);
        if (k == 0) begin : g_ex
            assign op_data[k] = hz_i_alu_data;
        end else if (k == LOAD_STAGE) begin : g_ld
            assign op_data[k] = ld_q[k] ? hz_i_load_data : data_q[k];
        end else begin : g_st
            assign op_data[k] = data_q[k];
        end
    end

    for (genvar n = 0; n < NUM_RS; n++) begin : g_port
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] sel;
        logic              hit;
        logic              rdy;

        assign addr = hz_i_addr_rs[n*AWIDTH +: AWIDTH];

        // Youngest matching entry wins: scan oldest to youngest, last match sticks.
        always_comb begin
            sel = hz_i_data_rs[n*DWIDTH +: DWIDTH];
            hit = 1'b0;
            rdy = 1'b1;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (vld_q[k] && we_q[k] && (rd_q[k] == addr) && (rd_q[k] != '0)) begin
                    sel = op_data[k];
                    hit = 1'b1;
                    rdy = rdy_w[k];
                end
            end
            if (hz_rst) begin
                sel = hz_i_data_rs[n*DWIDTH +: DWIDTH];
                hit = 1'b0;
                rdy = 1'b1;
            end
            if (addr == '0) begin
                sel = '0;
            end
        end

        assign hz_o_data_rs[n*DWIDTH +: DWIDTH] = sel;
        assign hz_o_fwd_hit[n]                  = hit;
        assign wait_w[n]                        = ~rdy;
    end

    assign stall_w        = ~hz_rst & hz_i_issue_valid & ~hz_i_flush & (|wait_w);
    assign hz_o_stall     = stall_w;
    assign hz_o_stall_cnt = cnt_q;

    // Advance the in-flight pipeline: issue or bubble into EX, capture results
    // as entries leave the stage that produces them, kill EX on flush.
    always_ff @(posedge hz_clk) begin
        if (hz_rst) begin
            vld_q <= '0;
            we_q  <= '0;
            ld_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= hz_i_issue_valid & ~stall_w & ~hz_i_flush;
            we_q[0]  <= hz_i_issue_we;
            rd_q[0]  <= hz_i_issue_rd;
            ld_q[0]  <= hz_i_issue_load;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                we_q[k]  <= we_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                ld_q[k]  <= ld_q[k-1];
            end
            data_q[1] <= hz_i_alu_data;
            for (int k = 2; k < STAGES; k++) begin
                if ((k == LOAD_STAGE + 1) && ld_q[k-1]) begin
                    data_q[k] <= hz_i_load_data;
                end else begin
                    data_q[k] <= data_q[k-1];
                end
            end
            if (hz_i_flush) begin
                vld_q[1] <= 1'b0;
            end
        end
    end

    // Stall-cycle performance counter, saturating at its maximum.
    always_ff @(posedge hz_clk) begin
        if (hz_rst) begin
            cnt_q <= '0;
        end else if (stall_w) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with a cycle-history reference model.
// The model remembers what was accepted into EX on every cycle and which ALU /
// load values were presented, and derives each operand from the age of the
// producing instruction.
module tb_hazard_scoreboard;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int ST   = 3;
    localparam int LS   = 1;
    localparam int MAXC = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, iv, iwe, ild, flush;
    logic [AW-1:0] ird, a0, a1;
    logic [DW-1:0] rf0, rf1, alu, ldd;

    logic [NR*AW-1:0] addr_rs;
    logic [NR*DW-1:0] data_rs;
    assign addr_rs = {a1, a0};
    assign data_rs = {rf1, rf0};

    logic [NR*DW-1:0] d_rs, d_rs2;
    logic [NR-1:0]    hit, hit2;
    logic             stall, stall2;
    logic [15:0]      cnt;
    logic [1:0]       cnt2;

    hazard_scoreboard #(.DWIDTH(DW), .AWIDTH(AW), .NUM_RS(NR), .STAGES(ST),
                        .LOAD_STAGE(LS), .CNT_WIDTH(16)) dut (
        .hz_clk(clk), .hz_rst(rst), .hz_i_issue_valid(iv), .hz_i_issue_we(iwe),
        .hz_i_issue_rd(ird), .hz_i_issue_load(ild), .hz_i_addr_rs(addr_rs),
        .hz_i_data_rs(data_rs), .hz_i_alu_data(alu), .hz_i_load_data(ldd),
        .hz_i_flush(flush), .hz_o_data_rs(d_rs), .hz_o_fwd_hit(hit),
        .hz_o_stall(stall), .hz_o_stall_cnt(cnt));

    hazard_scoreboard #(.DWIDTH(DW), .AWIDTH(AW), .NUM_RS(NR), .STAGES(ST),
                        .LOAD_STAGE(LS), .CNT_WIDTH(2)) dut2 (
        .hz_clk(clk), .hz_rst(rst), .hz_i_issue_valid(iv), .hz_i_issue_we(iwe),
        .hz_i_issue_rd(ird), .hz_i_issue_load(ild), .hz_i_addr_rs(addr_rs),
        .hz_i_data_rs(data_rs), .hz_i_alu_data(alu), .hz_i_load_data(ldd),
        .hz_i_flush(flush), .hz_o_data_rs(d_rs2), .hz_o_fwd_hit(hit2),
        .hz_o_stall(stall2), .hz_o_stall_cnt(cnt2));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle history for the model.
    logic          rst_h   [MAXC];
    logic          flush_h [MAXC];
    logic          acc_v   [MAXC];
    logic          acc_we  [MAXC];
    logic          acc_ld  [MAXC];
    logic [AW-1:0] acc_rd  [MAXC];
    logic [DW-1:0] alu_h   [MAXC];
    logic [DW-1:0] ld_h    [MAXC];
    int            t = 0;
    int            cnt_exp = 0;
    int            cnt2_exp = 0;

    // Operand seen at cycle t: the most recently accepted, still-alive
    // instruction writing that register; its value is the ALU output of the
    // cycle after acceptance, or for a load old enough, the load data presented
    // LS cycles later.
    function automatic void model_port(input int tc, input logic [AW-1:0] a,
                                       input logic [DW-1:0] rf, output logic [DW-1:0] d,
                                       output logic h, output logic r);
        int c;
        d = rf;
        h = 1'b0;
        r = 1'b1;
        if (!rst_h[tc]) begin
            for (int k = 0; k < ST; k++) begin
                c = tc - k - 1;
                if (c < 0) break;
                if (rst_h[c]) break;
                if (!acc_v[c] || ((c + 1 < tc) && flush_h[c+1])) continue;
                if (acc_we[c] && (acc_rd[c] == a) && (a != 0)) begin
                    h = 1'b1;
                    r = !acc_ld[c] || (k >= LS);
                    d = (acc_ld[c] && (k >= LS)) ? ld_h[c+1+LS] : alu_h[c+1];
                    break;
                end
            end
        end
        if (a == 0) begin
            d = '0;
            h = 1'b0;
            r = 1'b1;
        end
    endfunction

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin : cmp
        logic [DW-1:0] e0, e1;
        logic          h0, h1, r0, r1, es;
        if (t < MAXC) begin
            rst_h[t]   = rst;
            flush_h[t] = flush;
            alu_h[t]   = alu;
            ld_h[t]    = ldd;
            model_port(t, a0, rf0, e0, h0, r0);
            model_port(t, a1, rf1, e1, h1, r1);
            es = !rst && iv && !flush && (!r0 || !r1);
            check("data_rs0", d_rs[31:0], e0);
            check("data_rs1", d_rs[63:32], e1);
            check("fwd_hit", {30'd0, hit}, {30'd0, h1, h0});
            check("stall", {31'd0, stall}, {31'd0, es});
            check("stall_cnt", {16'd0, cnt}, cnt_exp);
            check("w2_data_rs", d_rs2[63:32] ^ d_rs2[31:0], e1 ^ e0);
            check("w2_hit", {30'd0, hit2}, {30'd0, h1, h0});
            check("w2_stall", {31'd0, stall2}, {31'd0, es});
            check("w2_stall_cnt", {30'd0, cnt2}, cnt2_exp);
            acc_v[t]  = iv && !flush && !es && !rst;
            acc_we[t] = iwe;
            acc_rd[t] = ird;
            acc_ld[t] = ild;
            if (rst) begin
                cnt_exp  = 0;
                cnt2_exp = 0;
            end else if (es) begin
                if (cnt_exp < 65535) cnt_exp++;
                if (cnt2_exp < 3) cnt2_exp++;
            end
            t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 0; iwe = 0; ild = 0; ird = '0; flush = 0;
        a0 = 5'd1; a1 = 5'd2; rf0 = 32'h100; rf1 = 32'h200;
        alu = '0; ldd = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1; a0 = 5'd3; a1 = 5'd0; rf0 = 32'h12; rf1 = 32'h34;
        tick();
        #2;
        check("lit_rst_stall", {31'd0, stall}, 32'd0);
        check("lit_rst_hit", {30'd0, hit}, 32'd0);
        check("lit_rst_data0", d_rs[31:0], 32'h12);
        check("lit_rst_x0", d_rs[63:32], 32'h0);
        check("lit_rst_cnt", {16'd0, cnt}, 32'd0);
        tick();
        rst = 0; idle();

        // ALU read-after-write
        iv = 1; iwe = 1; ird = 5'd5;
        tick();
        idle(); alu = 32'h11; a0 = 5'd5; rf0 = 32'h0;
        #2;
        check("lit_alu_data0", d_rs[31:0], 32'h11);
        check("lit_alu_hit", {30'd0, hit}, 32'd1);
        check("lit_alu_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();

        // Load-use stall
        iv = 1; iwe = 1; ird = 5'd6; ild = 1;
        tick();
        idle(); iv = 1; a1 = 5'd6; rf1 = 32'h0;
        #2;
        check("lit_lu_stall", {31'd0, stall}, 32'd1);
        tick();
        ldd = 32'hDEADBEEF;
        #2;
        check("lit_lu_data1", d_rs[63:32], 32'hDEADBEEF);
        check("lit_lu_hit", {30'd0, hit}, 32'd2);
        check("lit_lu_stall2", {31'd0, stall}, 32'd0);
        check("lit_lu_cnt", {16'd0, cnt}, 32'd1);
        tick();
        idle();

        // Priority between two in-flight writes to x7
        iv = 1; iwe = 1; ird = 5'd7;
        tick();
        alu = 32'hA;
        tick();
        idle(); alu = 32'hB; a0 = 5'd7; a1 = 5'd7;
        #2;
        check("lit_pri_data0", d_rs[31:0], 32'hB);
        check("lit_pri_data1", d_rs[63:32], 32'hB);
        check("lit_pri_hit", {30'd0, hit}, 32'd3);
        tick();
        idle();

        // Writes to x0 are never forwarded
        iv = 1; iwe = 1; ird = 5'd0;
        tick();
        idle(); alu = 32'h5; a0 = 5'd0; rf0 = 32'h3;
        #2;
        check("lit_x0_data0", d_rs[31:0], 32'h0);
        check("lit_x0_hit0", {31'd0, hit[0]}, 32'd0);
        tick();
        idle();

        // Flush kills entry 0 and the issuing instruction
        iv = 1; iwe = 1; ird = 5'd8;
        tick();
        idle(); alu = 32'h22; flush = 1; iv = 1; iwe = 1; ird = 5'd10;
        tick();
        idle(); a0 = 5'd8; rf0 = 32'h99; a1 = 5'd10; rf1 = 32'h77;
        #2;
        check("lit_fl_data0", d_rs[31:0], 32'h99);
        check("lit_fl_data1", d_rs[63:32], 32'h77);
        check("lit_fl_hit", {30'd0, hit}, 32'd0);
        tick();
        tick();
        idle();

        // Four more load-use stalls to saturate the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            iv = 1; iwe = 1; ird = 5'd6; ild = 1;
            tick();
            idle(); iv = 1; a1 = 5'd6; ldd = 32'h1000 + i;
            tick();
            tick();
            idle();
        end
        #2;
        check("lit_sat_cnt", {16'd0, cnt}, 32'd5);
        check("lit_sat_cnt2", {30'd0, cnt2}, 32'd3);

        // Reset in the middle of a load-use stall
        iv = 1; iwe = 1; ird = 5'd9; ild = 1;
        tick();
        idle(); iv = 1; a0 = 5'd9; rf0 = 32'h55;
        #2;
        check("lit_rm_stall", {31'd0, stall}, 32'd1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        #2;
        check("lit_rm_stall_after", {31'd0, stall}, 32'd0);
        check("lit_rm_cnt", {16'd0, cnt}, 32'd0);
        check("lit_rm_cnt2", {30'd0, cnt2}, 32'd0);
        check("lit_rm_hit", {30'd0, hit}, 32'd0);
        check("lit_rm_data0", d_rs[31:0], 32'h55);
        tick();
        idle();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
